// File: rtl/ad_frame_buf_if.sv
// Output stream of the frame buffer: signed samples toward the spectral analysis stage.
interface ad_frame_buf_if #(
   parameter int OUT_W = 16
);
   logic [OUT_W-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ad_frame_buf.sv
// Captures one frame of offset-binary ADC samples per start request, then streams it out
// as sign-extended two's complement over valid/ready.
module ad_frame_buf #(
   parameter int DATA_W    = 10,
   parameter int OUT_W     = 16,
   parameter int FRAME_LEN = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic                clk_50m,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sample_en,
   input  logic [DATA_W-1:0]   ad_data,
   output logic                busy,
   output logic                done,
   ad_frame_buf_if.master      m
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                rd_all_q, rd_all_d;
   logic                ram_vld_q, ram_vld_d;
   logic                ram_last_q, ram_last_d;
   logic [OUT_W-1:0]    skid_data_q, skid_data_d;
   logic                skid_vld_q, skid_vld_d;
   logic                skid_last_q, skid_last_d;
   logic [OUT_W-1:0]    m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]        mem [FRAME_LEN];
   logic [DATA_W-1:0]        ram_rdata;
   logic signed [DATA_W-1:0] ram_signed;
   logic [OUT_W-1:0]         ram_conv;
   logic                     wr_en, rd_en, pop, out_free;
   logic [1:0]               occ_after;

   // Offset binary to two's complement is an MSB flip; the signed cast then sign-extends.
   assign ram_signed = {~ram_rdata[DATA_W-1], ram_rdata[DATA_W-2:0]};
   assign ram_conv   = OUT_W'(ram_signed);

   assign pop      = m_valid_q && m.m_ready;
   assign out_free = !m_valid_q || pop;

   // Reads in flight plus held beats never exceed the output register and skid entry.
   assign occ_after = 2'(m_valid_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop);
   assign rd_en     = (state_q == DRAIN) && !rd_all_q && (occ_after < 2'd2);

   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      rd_all_d    = rd_all_q;
      skid_data_d = skid_data_q;
      skid_vld_d  = skid_vld_q;
      skid_last_d = skid_last_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      done_d      = 1'b0;
      wr_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CAPTURE;
               wr_addr_d = '0;
            end
         end
         CAPTURE: begin
            if (sample_en) begin
               wr_en     = 1'b1;
               wr_addr_d = wr_addr_q + ADDR_W'(1);
               if (wr_addr_q == LAST_ADDR) begin
                  state_d   = DRAIN;
                  rd_addr_d = '0;
                  rd_all_d  = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (pop && m_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_en) begin
         rd_addr_d = rd_addr_q + ADDR_W'(1);
         if (rd_addr_q == LAST_ADDR) rd_all_d = 1'b1;
      end
      ram_vld_d  = rd_en;
      ram_last_d = rd_en && (rd_addr_q == LAST_ADDR);

      if (out_free) begin
         if (skid_vld_q) begin
            m_data_d    = skid_data_q;
            m_last_d    = skid_last_q;
            m_valid_d   = 1'b1;
            skid_vld_d  = ram_vld_q;
            skid_data_d = ram_conv;
            skid_last_d = ram_last_q;
         end else if (ram_vld_q) begin
            m_data_d  = ram_conv;
            m_last_d  = ram_last_q;
            m_valid_d = 1'b1;
         end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      end else if (ram_vld_q) begin
         skid_vld_d  = 1'b1;
         skid_data_d = ram_conv;
         skid_last_d = ram_last_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         rd_all_q    <= 1'b0;
         ram_vld_q   <= 1'b0;
         ram_last_q  <= 1'b0;
         skid_data_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_last_q <= 1'b0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         rd_all_q    <= rd_all_d;
         ram_vld_q   <= ram_vld_d;
         ram_last_q  <= ram_last_d;
         skid_data_q <= skid_data_d;
         skid_vld_q  <= skid_vld_d;
         skid_last_q <= skid_last_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Sample RAM: no reset, contents are don't-care until written.
   always_ff @(posedge clk_50m) begin
      if (wr_en) mem[wr_addr_q] <= ad_data;
      if (rd_en) ram_rdata <= mem[rd_addr_q];
   end

   assign m.m_data  = m_data_q;
   assign m.m_valid = m_valid_q;
   assign m.m_last  = m_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ad_frame_buf.sv
// Scoreboard bench for ad_frame_buf: expected beats are queued as samples are strobed in
// and popped by a monitor as the stream is accepted.
module tb_ad_frame_buf;
   localparam int DW = 10;
   localparam int OW = 16;
   localparam int FL = 1024;
   localparam int AW = 10;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk_50m = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          sample_en = 1'b0;
   logic [DW-1:0] ad_data = '0;
   logic          busy, done;

   ad_frame_buf_if #(.OUT_W(OW)) s_if ();

   ad_frame_buf #(.DATA_W(DW), .OUT_W(OW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .start    (start),
      .sample_en(sample_en),
      .ad_data  (ad_data),
      .busy     (busy),
      .done     (done),
      .m        (s_if)
   );

   always #10 clk_50m = ~clk_50m;

   beat_t         sb[$];
   int            n_pass = 0;
   int            n_chk = 0;
   int            cyc = 0;
   int            beat_cnt = 0;
   int            first_cyc = 0;
   int            last_cyc = 0;
   bit            rnd_ready = 1'b0;
   bit            pend_done = 1'b0;
   logic [OW-1:0] first4[4];
   logic [DW-1:0] ext_in[4] = '{10'd0, 10'd1023, 10'd512, 10'd511};
   logic [OW-1:0] ext_out[4] = '{16'hFE00, 16'h01FF, 16'h0000, 16'hFFFF};

   function automatic logic [OW-1:0] model(input logic [DW-1:0] v);
      return OW'(int'(v) - (1 << (DW - 1)));
   endfunction

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   initial forever begin
      @(posedge clk_50m);
      #1;
      s_if.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: pops the scoreboard on each accepted beat, checks stall stability and done timing.
   initial begin : monitor
      beat_t         e;
      logic          prev_v, prev_r, prev_l;
      logic [OW-1:0] prev_d;
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
      forever begin
         @(negedge clk_50m);
         cyc++;
         if (!rst_n) begin
            pend_done = 1'b0;
            prev_v = 1'b0;
         end else begin
            if (pend_done) begin
               n_chk++;
               if (done !== 1'b1 || s_if.m_valid !== 1'b0)
                  $display("FAIL done_pulse: done=%b m_valid=%b, expected done=1 m_valid=0", done, s_if.m_valid);
               else n_pass++;
               pend_done = 1'b0;
            end else if (done === 1'b1) begin
               n_chk++;
               $display("FAIL spurious_done: done=1 at cycle %0d, expected 0", cyc);
            end
            if (prev_v && !prev_r) begin
               n_chk++;
               if (s_if.m_valid !== 1'b1 || s_if.m_data !== prev_d || s_if.m_last !== prev_l)
                  $display("FAIL stall_hold: v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                           s_if.m_valid, s_if.m_data, s_if.m_last, prev_d, prev_l);
               else n_pass++;
            end
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
               n_chk++;
               if (sb.size() == 0) begin
                  $display("FAIL extra_beat: got d=%h l=%b, expected no beat", s_if.m_data, s_if.m_last);
               end else begin
                  e = sb.pop_front();
                  if (s_if.m_data !== e.data || s_if.m_last !== e.last)
                     $display("FAIL beat %0d: got d=%h l=%b, expected d=%h l=%b",
                              beat_cnt, s_if.m_data, s_if.m_last, e.data, e.last);
                  else n_pass++;
               end
               if (beat_cnt < 4) first4[beat_cnt] = s_if.m_data;
               if (beat_cnt == 0) first_cyc = cyc;
               last_cyc = cyc;
               beat_cnt++;
               if (s_if.m_last === 1'b1) pend_done = 1'b1;
            end
            prev_v = s_if.m_valid; prev_r = s_if.m_ready;
            prev_d = s_if.m_data;  prev_l = s_if.m_last;
         end
      end
   end

   // pat: 0 ramp, 1 extremes, 2 random. pre: start was already driven during a done cycle.
   task automatic capture(input int period, input int pat, input bit pre, input bit inject);
      logic [DW-1:0] v;
      beat_t         e;
      sb.delete();
      beat_cnt = 0;
      if (!pre) begin
         start = 1'b1;
         sample_en = 1'b1;
         ad_data = 10'h155;
      end
      tick();
      start = 1'b0;
      sample_en = 1'b0;
      n_chk++;
      if (busy !== 1'b1) $display("FAIL busy_rise: busy=%b, expected 1", busy);
      else n_pass++;
      for (int i = 0; i < FL; i++) begin
         if (pat == 0) v = DW'(i);
         else if (pat == 1) v = ext_in[i % 4];
         else v = DW'($urandom_range(0, 1023));
         sample_en = 1'b1;
         ad_data = v;
         e.data = model(v);
         e.last = (i == FL - 1);
         sb.push_back(e);
         if (inject && i == 100) start = 1'b1;
         tick();
         sample_en = 1'b0;
         start = 1'b0;
         repeat (period - 1) tick();
      end
   endtask

   task automatic wait_done(input bit inject, input bit nobub, input string tag);
      bit got = 1'b0;
      for (int c = 0; c < 20000 && !got; c++) begin
         @(negedge clk_50m);
         #1;
         if (done === 1'b1) begin
            got = 1'b1;
            sample_en = 1'b0;
            start = 1'b0;
         end else if (inject) begin
            sample_en = (c % 3 == 0);
            ad_data = DW'(c);
            start = (c == 20);
         end
      end
      n_chk++;
      if (!got) $display("FAIL %s_timeout: no done within bound, expected done", tag);
      else n_pass++;
      n_chk++;
      if (sb.size() != 0 || beat_cnt != FL)
         $display("FAIL %s_count: beats=%0d pending=%0d, expected %0d and 0", tag, beat_cnt, sb.size(), FL);
      else n_pass++;
      if (nobub) begin
         n_chk++;
         if (last_cyc - first_cyc != FL - 1)
            $display("FAIL %s_span: %0d cycles, expected %0d", tag, last_cyc - first_cyc + 1, FL);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #3;
      n_chk++;
      if ({s_if.m_valid, s_if.m_last, s_if.m_data, busy, done} !== '0)
         $display("FAIL reset_vals: v=%b l=%b d=%h busy=%b done=%b, expected all 0",
                  s_if.m_valid, s_if.m_last, s_if.m_data, busy, done);
      else n_pass++;
      repeat (3) @(negedge clk_50m);
      rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      capture(24, 0, 1'b0, 1'b0);
      wait_done(1'b0, 1'b1, "ramp");
   endtask

   task automatic test_backpressure();
      rnd_ready = 1'b1;
      capture(3, 0, 1'b0, 1'b0);
      wait_done(1'b0, 1'b0, "bp");
      rnd_ready = 1'b0;
   endtask

   task automatic test_ignored();
      tick();
      for (int i = 0; i < 6; i++) begin
         sample_en = 1'b1;
         ad_data = DW'(i * 77);
         tick();
      end
      sample_en = 1'b0;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL idle_strobe: busy=%b, expected 0", busy);
      else n_pass++;
      capture(2, 2, 1'b0, 1'b1);
      wait_done(1'b1, 1'b0, "ign");
      repeat (3) tick();
      n_chk++;
      if (busy !== 1'b0 || s_if.m_valid !== 1'b0)
         $display("FAIL ign_idle: busy=%b m_valid=%b, expected 0 0", busy, s_if.m_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] vseq;
      for (int f = 0; f < 2; f++) begin
         capture(1, 2, f == 1, 1'b0);
         @(negedge clk_50m); vseq[2] = s_if.m_valid;
         @(negedge clk_50m); vseq[1] = s_if.m_valid;
         @(negedge clk_50m); vseq[0] = s_if.m_valid;
         n_chk++;
         if (vseq !== 3'b001) $display("FAIL latency: m_valid seq=%b, expected 001", vseq);
         else n_pass++;
         wait_done(1'b0, 1'b1, "b2b");
         n_chk++;
         if (busy !== 1'b0) $display("FAIL done_busy: busy=%b, expected 0", busy);
         else n_pass++;
         if (f == 0) start = 1'b1;
      end
   endtask

   task automatic test_mid_reset();
      bit hit = 1'b0;
      sb.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 500; i++) begin
         sample_en = 1'b1;
         ad_data = DW'(i);
         tick();
      end
      sample_en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({s_if.m_valid, s_if.m_last, s_if.m_data, busy, done} !== '0)
         $display("FAIL cap_reset: v=%b l=%b d=%h busy=%b done=%b, expected all 0",
                  s_if.m_valid, s_if.m_last, s_if.m_data, busy, done);
      else n_pass++;
      @(negedge clk_50m);
      rst_n = 1'b1;

      capture(1, 2, 1'b0, 1'b0);
      for (int c = 0; c < 5000 && !hit; c++) begin
         @(negedge clk_50m);
         #1;
         if (beat_cnt >= 300) hit = 1'b1;
      end
      n_chk++;
      if (!hit || s_if.m_valid !== 1'b1)
         $display("FAIL drain_reach: beats=%0d v=%b, expected >=300 and v=1", beat_cnt, s_if.m_valid);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({s_if.m_valid, s_if.m_last, s_if.m_data, busy, done} !== '0)
         $display("FAIL drain_reset: v=%b l=%b d=%h busy=%b done=%b, expected all 0",
                  s_if.m_valid, s_if.m_last, s_if.m_data, busy, done);
      else n_pass++;
      sb.delete();
      @(negedge clk_50m);
      rst_n = 1'b1;
      repeat (5) tick();
      capture(2, 0, 1'b0, 1'b0);
      wait_done(1'b0, 1'b1, "post_rst");
   endtask

   task automatic test_extremes();
      capture(2, 1, 1'b0, 1'b0);
      wait_done(1'b0, 1'b0, "ext");
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (first4[i] !== ext_out[i])
            $display("FAIL extreme %0d: in=%0d got=%h, expected %h", i, ext_in[i], first4[i], ext_out[i]);
         else n_pass++;
      end
   endtask

   initial begin
      s_if.m_ready = 1'b1;
      test_reset();
      test_ramp();
      test_backpressure();
      test_ignored();
      test_back_to_back();
      test_mid_reset();
      test_extremes();
      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
